// File: rtl/trdb_pkg.sv
// Shared trace-debugger types: address/cause widths and the retired-instruction record.
package trdb_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned CAUSELEN = 5;

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     addr;
    logic                exc;
    logic [CAUSELEN-1:0] cause;
    logic                qual;
  } trdb_instr_t;

endpackage

// File: rtl/trdb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module trdb_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/trdb_qual_tracker.sv
// One-instruction lookahead window that tags each retired instruction with qualification
// context (first/last qualified, skip count). Skip counter built only with TRDB_SKIP_COUNT_EN.
module trdb_qual_tracker
  import trdb_pkg::*;
#(
  parameter int unsigned SKIPW = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ivalid_i,
  input  logic [XLEN-1:0]     iaddr_i,
  input  logic                iexception_i,
  input  logic [CAUSELEN-1:0] cause_i,
  input  logic                qualified_i,
  input  logic                flush_i,
  output logic                valid_o,
  output logic [XLEN-1:0]     iaddr_o,
  output logic                exception_o,
  output logic [CAUSELEN-1:0] cause_o,
  output logic                qualified_o,
  output logic                first_qualified_o,
  output logic                last_qualified_o,
  output logic [SKIPW-1:0]    skip_cnt_o
);

  trdb_instr_t      nxt_q, nxt_d;
  logic             prev_qual_q, prev_qual_d;
  logic             flush_pend_q, flush_pend_d;
  trdb_instr_t      rec_q, rec_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic [SKIPW-1:0] skip_q, skip_d;

  logic             emit;
  logic             succ_qual;
  logic [SKIPW-1:0] skip_val;

`ifdef TRDB_SKIP_COUNT_EN
  trdb_sat_counter #(
    .Width(SKIPW)
  ) u_skip_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc_i (emit & ~nxt_q.qual),
    .clr_i (emit & nxt_q.qual),
    .cnt_o (skip_val)
  );
`else
  assign skip_val = '0;
`endif

  always_comb begin
    emit         = 1'b0;
    succ_qual    = 1'b0;
    nxt_d        = nxt_q;
    prev_qual_d  = prev_qual_q;
    flush_pend_d = flush_pend_q;

    if (ivalid_i) begin
      // Accept beats drain; a pending drain waits until a cycle without input.
      emit         = nxt_q.valid;
      succ_qual    = qualified_i;
      nxt_d.valid  = 1'b1;
      nxt_d.addr   = iaddr_i;
      nxt_d.exc    = iexception_i;
      nxt_d.cause  = cause_i;
      nxt_d.qual   = qualified_i;
      if (flush_i) begin
        flush_pend_d = 1'b1;
      end
      if (emit) begin
        prev_qual_d = nxt_q.qual;
      end
    end else if (flush_i || flush_pend_q) begin
      emit         = nxt_q.valid;
      nxt_d.valid  = 1'b0;
      prev_qual_d  = 1'b0;
      flush_pend_d = 1'b0;
    end
  end

  always_comb begin
    rec_d       = rec_q;
    rec_d.valid = 1'b0;
    first_d     = first_q;
    last_d      = last_q;
    skip_d      = skip_q;
    if (emit) begin
      rec_d       = nxt_q;
      rec_d.valid = 1'b1;
      first_d     = nxt_q.qual & ~prev_qual_q;
      last_d      = nxt_q.qual & ~succ_qual;
      skip_d      = nxt_q.qual ? skip_val : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      nxt_q        <= '0;
      prev_qual_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      rec_q        <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      skip_q       <= '0;
    end else begin
      nxt_q        <= nxt_d;
      prev_qual_q  <= prev_qual_d;
      flush_pend_q <= flush_pend_d;
      rec_q        <= rec_d;
      first_q      <= first_d;
      last_q       <= last_d;
      skip_q       <= skip_d;
    end
  end

  assign valid_o           = rec_q.valid;
  assign iaddr_o           = rec_q.addr;
  assign exception_o       = rec_q.exc;
  assign cause_o           = rec_q.cause;
  assign qualified_o       = rec_q.qual;
  assign first_qualified_o = first_q;
  assign last_qualified_o  = last_q;
  assign skip_cnt_o        = skip_q;

endmodule

// File: tb/tb_trdb_qual_tracker.sv
// Bench for trdb_qual_tracker: queue-based reference model, per-cycle compare, directed cases.
module tb_trdb_qual_tracker;
  import trdb_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                ivalid, iexc, qual, flush;
  logic [XLEN-1:0]     iaddr;
  logic [CAUSELEN-1:0] cause;

  logic                a_valid, a_exc, a_qual, a_first, a_last;
  logic [XLEN-1:0]     a_addr;
  logic [CAUSELEN-1:0] a_cause;
  logic [15:0]         a_skip;
  logic                b_valid, b_exc, b_qual, b_first, b_last;
  logic [XLEN-1:0]     b_addr;
  logic [CAUSELEN-1:0] b_cause;
  logic [1:0]          b_skip;

  always #5 clk = ~clk;

  trdb_qual_tracker #(.SKIPW(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .ivalid_i(ivalid), .iaddr_i(iaddr), .iexception_i(iexc),
    .cause_i(cause), .qualified_i(qual), .flush_i(flush), .valid_o(a_valid),
    .iaddr_o(a_addr), .exception_o(a_exc), .cause_o(a_cause), .qualified_o(a_qual),
    .first_qualified_o(a_first), .last_qualified_o(a_last), .skip_cnt_o(a_skip)
  );

  trdb_qual_tracker #(.SKIPW(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .ivalid_i(ivalid), .iaddr_i(iaddr), .iexception_i(iexc),
    .cause_i(cause), .qualified_i(qual), .flush_i(flush), .valid_o(b_valid),
    .iaddr_o(b_addr), .exception_o(b_exc), .cause_o(b_cause), .qualified_o(b_qual),
    .first_qualified_o(b_first), .last_qualified_o(b_last), .skip_cnt_o(b_skip)
  );

`ifdef TRDB_SKIP_COUNT_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  typedef struct {
    logic [XLEN-1:0]     addr;
    bit                  exc;
    logic [CAUSELEN-1:0] cause;
    bit                  qual;
  } rec_t;

  typedef struct {
    logic [XLEN-1:0] addr;
    bit              qual, first, last;
    int unsigned     skip_a, skip_b;
  } log_t;

  // Reference model state: accepted-but-not-emitted instructions and qualification history.
  rec_t        win[$];
  bit          fpend, prevq;
  int unsigned raw;
  bit          e_valid, e_exc, e_qual, e_first, e_last;
  logic [XLEN-1:0]     e_addr;
  logic [CAUSELEN-1:0] e_cause;
  int unsigned e_skip;

  log_t log_q[$];
  int   n_pass = 0, n_chk = 0;
  bit   started = 1'b0;

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic int unsigned sat(int unsigned v, int unsigned maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic void emit(rec_t r, bit succ);
    e_valid = 1'b1;
    e_addr  = r.addr;
    e_exc   = r.exc;
    e_cause = r.cause;
    e_qual  = r.qual;
    e_first = r.qual && !prevq;
    e_last  = r.qual && !succ;
    if (r.qual) begin
      e_skip = raw;
      raw    = 0;
    end else begin
      e_skip = 0;
      if (raw != 32'hFFFF_FFFF) raw++;
    end
    prevq = r.qual;
  endfunction

  function automatic void model_step();
    rec_t r;
    e_valid = 1'b0;
    if (!rst_n) begin
      win.delete();
      fpend = 1'b0;
      prevq = 1'b0;
      raw   = 0;
      return;
    end
    if (ivalid) begin
      if (win.size() > 0) emit(win.pop_front(), qual);
      r.addr = iaddr; r.exc = iexc; r.cause = cause; r.qual = qual;
      win.push_back(r);
      if (flush) fpend = 1'b1;
    end else if (flush || fpend) begin
      if (win.size() > 0) emit(win.pop_front(), 1'b0);
      prevq = 1'b0;
      fpend = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("valid_a", a_valid, e_valid);
      chk("valid_b", b_valid, e_valid);
      if (e_valid) begin
        chk("addr_a", a_addr, e_addr);
        chk("exc_a", a_exc, e_exc);
        chk("cause_a", a_cause, e_cause);
        chk("qual_a", a_qual, e_qual);
        chk("first_a", a_first, e_first);
        chk("last_a", a_last, e_last);
        chk("skip_a", a_skip, SkipEn ? sat(e_skip, 65535) : 0);
        chk("addr_b", b_addr, e_addr);
        chk("first_b", b_first, e_first);
        chk("last_b", b_last, e_last);
        chk("skip_b", b_skip, SkipEn ? sat(e_skip, 3) : 0);
      end
      if (a_valid) log_q.push_back('{a_addr, a_qual, a_first, a_last, a_skip, b_skip});
    end
  end

  task automatic drive(bit v, logic [XLEN-1:0] a, bit q, bit f,
                       bit e = 1'b0, logic [CAUSELEN-1:0] c = '0);
    ivalid = v; iaddr = a; qual = q; flush = f; iexc = e; cause = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk_log(string name, int idx, logic [XLEN-1:0] addr, bit q, bit f, bit l);
    if (idx >= log_q.size()) begin
      chk({name, "_present"}, log_q.size(), idx + 1);
    end else begin
      chk({name, "_addr"}, log_q[idx].addr, addr);
      chk({name, "_qual"}, log_q[idx].qual, q);
      chk({name, "_first"}, log_q[idx].first, f);
      chk({name, "_last"}, log_q[idx].last, l);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ivalid = 1'b0; iaddr = '0; qual = 1'b0; flush = 1'b0; iexc = 1'b0; cause = '0;
    started = 1'b1;
    idle(2);
    chk("rst_valid", a_valid, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_flags", {a_qual, a_first, a_last, a_exc}, 0);
    chk("rst_skip", a_skip, 0);
    rst_n = 1'b1;
    idle(1);

    // Qualification 0,1,1,0 then flush.
    log_q.delete();
    drive(1, 32'h100, 0, 0);
    drive(1, 32'h104, 1, 0);
    drive(1, 32'h108, 1, 0);
    drive(1, 32'h10C, 0, 0);
    drive(0, '0, 0, 1);
    idle(2);
    chk("seq_count", log_q.size(), 4);
    chk_log("seq0", 0, 32'h100, 0, 0, 0);
    chk_log("seq1", 1, 32'h104, 1, 1, 0);
    chk_log("seq2", 2, 32'h108, 1, 0, 1);
    chk_log("seq3", 3, 32'h10C, 0, 0, 0);

    // Single qualified instruction drained by a lone flush.
    drive(1, 32'h200, 1, 0);
    drive(0, '0, 0, 1);
    chk("single_valid", a_valid, 1);
    chk("single_addr", a_addr, 32'h200);
    chk("single_fl", {a_first, a_last}, 2'b11);
    idle(2);

    // Flush coincident with an accept.
    log_q.delete();
    drive(1, 32'h2FC, 1, 0);
    drive(1, 32'h300, 1, 1);
    idle(3);
    chk("coinc_count", log_q.size(), 2);
    chk_log("coinc0", 0, 32'h2FC, 1, 1, 0);
    chk_log("coinc1", 1, 32'h300, 1, 0, 1);

    // Five skips then a qualified instruction.
    log_q.delete();
    for (int i = 0; i < 5; i++) drive(1, 32'h3E0 + 32'(4 * i), 0, 0);
    drive(1, 32'h400, 1, 0);
    drive(0, '0, 0, 1);
    idle(2);
    chk("skip_count", log_q.size(), 6);
    chk_log("skip5", 5, 32'h400, 1, 1, 1);
    if (log_q.size() == 6) begin
      chk("skip_a_val", log_q[5].skip_a, SkipEn ? 5 : 0);
      chk("skip_b_sat", log_q[5].skip_b, SkipEn ? 3 : 0);
    end

    // Reset while 0x500 sits in the window.
    log_q.delete();
    drive(1, 32'h500, 1, 0);
    rst_n = 1'b0;
    drive(0, '0, 0, 1);
    chk("rst_mid_valid", a_valid, 0);
    rst_n = 1'b1;
    drive(0, '0, 0, 1);
    drive(1, 32'h504, 1, 0);
    drive(1, 32'h508, 0, 0);
    drive(0, '0, 0, 1);
    idle(2);
    chk("rst_mid_count", log_q.size(), 2);
    chk_log("rst_mid0", 0, 32'h504, 1, 1, 1);

    // Back-to-back qualified stream of eight.
    log_q.delete();
    for (int i = 0; i < 8; i++) drive(1, 32'h600 + 32'(4 * i), 1, 0);
    drive(0, '0, 0, 1);
    chk("b2b_pre_flush", log_q.size(), 7);
    idle(2);
    chk("b2b_count", log_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk_log("b2b", i, 32'h600 + 32'(4 * i), 1, i == 0, i == 7);
    end

    // Randomized traffic with runs of qualification, flushes and occasional resets.
    begin
      bit q = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(3) == 0) q = ~q;
        rst_n = ($urandom_range(199) != 0);
        drive($urandom_range(3) != 0, $urandom, q, $urandom_range(15) == 0,
              $urandom_range(7) == 0, CAUSELEN'($urandom));
      end
      rst_n = 1'b1;
      drive(0, '0, 0, 1);
      idle(3);
    end

    started = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
